// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants, flag indices and operand classifiers
// for the streaming multiplier front-end.
package fp_pkg;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    localparam int FLG_INVALID  = 2;
    localparam int FLG_OVERFLOW = 1;
    localparam int FLG_NAN_IN   = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [2:0]  flags;
    } fp_result_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
    endfunction

    // Subnormals are deliberately not zero here: only an all-zero magnitude counts.
    function automatic logic is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction
endpackage

// File: rtl/fp_result_fifo.sv
// Show-ahead result FIFO; the head is visible combinationally from the storage
// array and reads as zero while empty. Pops on an empty FIFO are ignored.
module fp_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             pop;

    assign rd_valid = (count_reg != '0);
    assign pop      = rd_en && rd_valid;
    assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;
    assign count    = count_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (wr_en && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!wr_en && pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp_tree_multiplier.sv
// Combinational single-precision multiplier: partial-product adder tree, round to
// nearest even, subnormal inputs and underflowing results flushed to signed zero.
module fp_tree_multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow
);
    logic [23:0] ma, mb;
    logic [47:0] l0 [32];
    logic [47:0] l1 [16];
    logic [47:0] l2 [8];
    logic [47:0] l3 [4];
    logic [47:0] l4 [2];
    logic [47:0] prod;

    assign ma = {1'b1, a[22:0]};
    assign mb = {1'b1, b[22:0]};

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_leaf
            if (gi < 24) begin : g_pp
                assign l0[gi] = mb[gi] ? (48'(ma) << gi) : 48'd0;
            end else begin : g_pad
                assign l0[gi] = 48'd0;
            end
        end
        for (genvar gi = 0; gi < 16; gi++) begin : g_l1
            assign l1[gi] = l0[2*gi] + l0[2*gi+1];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_l2
            assign l2[gi] = l1[2*gi] + l1[2*gi+1];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_l3
            assign l3[gi] = l2[2*gi] + l2[2*gi+1];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_l4
            assign l4[gi] = l3[2*gi] + l3[2*gi+1];
        end
    endgenerate

    assign prod = l4[0] + l4[1];

    logic               sign;
    logic signed [10:0] exp_n;
    logic [22:0]        mant;
    logic [23:0]        mant_r;
    logic               guard, sticky;

    always_comb begin
        sign     = a[31] ^ b[31];
        exp_n    = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
        overflow = 1'b0;
        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_n + 11'sd1;
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        mant_r = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
        // A rounding carry leaves the mantissa field at zero, only the exponent moves.
        if (mant_r[23]) begin
            exp_n = exp_n + 11'sd1;
        end
        if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0) || (exp_n <= 11'sd0)) begin
            result = {sign, 31'd0};
        end else if (exp_n >= 11'sd255) begin
            result   = {sign, 8'hFF, 23'd0};
            overflow = 1'b1;
        end else begin
            result = {sign, exp_n[7:0], mant_r[22:0]};
        end
    end
endmodule

// File: rtl/fp_mul_stream.sv
// Streaming single-precision multiplier: operand stage, special-case fixup, result
// FIFO and sticky exception flags (sticky register only with FP_MUL_STICKY_FLAGS_EN).
module fp_mul_stream
    import fp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic [2:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic [2:0]               sticky_flags,
    input  logic                     clear_flags
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic        s1_valid_reg;
    logic [31:0] s1_a_reg, s1_b_reg;
    logic [31:0] mul_result;
    logic        mul_overflow;
    logic        fifo_wr_ok, accept, push;
    fp_result_t  fix_res, head;

    // Popping a full FIFO frees its slot for this cycle's write.
    assign fifo_wr_ok = (count < CW'(DEPTH)) || (out_valid && out_ready);
    assign in_ready   = !s1_valid_reg || fifo_wr_ok;
    assign accept     = in_valid && in_ready;
    assign push       = s1_valid_reg && fifo_wr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
        end else if (push) begin
            s1_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a_reg <= in_a;
            s1_b_reg <= in_b;
        end
    end

    fp_tree_multiplier u_mul (
        .a        (s1_a_reg),
        .b        (s1_b_reg),
        .result   (mul_result),
        .overflow (mul_overflow)
    );

    logic res_sign;

    always_comb begin
        res_sign                    = s1_a_reg[31] ^ s1_b_reg[31];
        fix_res.result              = mul_result;
        fix_res.flags               = 3'b000;
        fix_res.flags[FLG_OVERFLOW] = mul_overflow;
        if (is_nan(s1_a_reg) || is_nan(s1_b_reg)) begin
            fix_res.result             = QNAN;
            fix_res.flags              = 3'b000;
            fix_res.flags[FLG_INVALID] = 1'b1;
            fix_res.flags[FLG_NAN_IN]  = 1'b1;
        end else if ((is_inf(s1_a_reg) && is_zero(s1_b_reg)) ||
                     (is_zero(s1_a_reg) && is_inf(s1_b_reg))) begin
            fix_res.result             = QNAN;
            fix_res.flags              = 3'b000;
            fix_res.flags[FLG_INVALID] = 1'b1;
        end else if (is_inf(s1_a_reg) || is_inf(s1_b_reg)) begin
            fix_res.result = {res_sign, POS_INF[30:0]};
            fix_res.flags  = 3'b000;
        end else if (is_zero(s1_a_reg) || is_zero(s1_b_reg)) begin
            fix_res.result = {res_sign, 31'd0};
            fix_res.flags  = 3'b000;
        end
    end

    fp_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (35)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push),
        .wr_data  (fix_res),
        .rd_en    (out_ready),
        .rd_data  (head),
        .rd_valid (out_valid),
        .count    (count)
    );

    assign out_result = head.result;
    assign out_flags  = head.flags;

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic [2:0] sticky_reg;

    // A clear coinciding with a write keeps only the written entry's flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_reg <= 3'b000;
        end else if (clear_flags) begin
            sticky_reg <= push ? fix_res.flags : 3'b000;
        end else if (push) begin
            sticky_reg <= sticky_reg | fix_res.flags;
        end
    end

    assign sticky_flags = sticky_reg;
`else
    logic unused_clear_flags;
    assign unused_clear_flags = clear_flags;
    assign sticky_flags       = 3'b000;
`endif
endmodule

// File: doc/fp_mul_stream.md
# fp_mul_stream

Streaming front-end and result stage around the combinational `fp_tree_multiplier`. It accepts IEEE-754 single-precision operand pairs over a valid/ready handshake and registers them into an operand stage that drives the multiplier. It then corrects the special-case result (NaN, infinity, zero), attaches per-result exception flags, and buffers results in a show-ahead FIFO for the downstream consumer. Sticky exception flags accumulate for the control/status block.

## Interface
- `DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept a pair this cycle.
- `in_a`, `in_b`  in  32  IEEE-754 single operands.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes head this cycle.
- `out_result`  out  32  head product.
- `out_flags`  out  3  head flags {invalid, overflow, nan_in}.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `sticky_flags`  out  3  OR of all flags written since reset or clear.
- `clear_flags`  in  1  clear sticky flags.

## Operation
- **Accept.** A transfer occurs when `in_valid && in_ready`. It loads the S1 operand register and sets `s1_valid`.
- **Ready.** `in_ready = !s1_valid || fifo_wr_ok`, where `fifo_wr_ok = (count < DEPTH) || (out_valid && out_ready)`. Pop-while-full frees the slot in the same cycle.
- **Multiply.** S1 drives `fp_tree_multiplier`. The fixup logic then overrides its result as follows:
  - Either operand NaN (exp=FF, mant≠0): result 7FC00000, flags nan_in=1, invalid=1.
  - Infinity × zero: 7FC00000, invalid=1. Zero means exp=0 and mant=0 exactly; subnormals are not zero.
  - Infinity × nonzero or infinity: sign XOR, 7F800000 magnitude, overflow=0.
  - Zero × finite: signed zero (sign XOR).
  - Otherwise: multiplier result, with overflow taken from the multiplier output. Overflowed results are ±7F800000.
- **Write.** When `s1_valid && fifo_wr_ok`, the fixed-up {result, flags} is written to the FIFO tail. If no new operand is accepted in the same cycle, `s1_valid` clears.
- **Stall.** If `s1_valid` is set and the FIFO cannot be written, S1 holds its contents and `in_ready` is 0.
- **FIFO.** Show-ahead; `out_result`/`out_flags` reflect the head whenever `out_valid` is high.
  - Simultaneous push and pop leaves `count` unchanged.
  - Pointers wrap modulo DEPTH.
- **Sticky flags.**
  - On each FIFO write: `sticky_flags |= flags`.
  - `clear_flags` zeroes the register.
  - Clear and write in the same cycle: the result is the written entry's flags only.
- **Reset.** A synchronous reset mid-operation discards S1 and all FIFO contents.

## Timing
- Reset values: `in_ready`=1 (S1 empty), `out_valid`=0, `count`=0, `out_result`=0, `out_flags`=0, `sticky_flags`=0.
- **Latency.** Input handshake at edge k; FIFO write at edge k+1; `out_valid` is high after edge k+1. That is 2 cycles with an empty FIFO and `out_ready`=1.
- **Throughput.** One pair per cycle sustained while `out_ready`=1.
- **Combinational paths.** `in_ready` depends combinationally on `out_ready`. No other combinational input→output paths exist.
- **Full.** With `count`=DEPTH, S1 valid and `out_ready`=0: `in_ready`=0 and nothing is lost.
- **Empty.** With `count`=0: `out_valid`=0, and `out_ready` is ignored.

## Configuration
- `FP_MUL_STICKY_FLAGS_EN` defined: the sticky flag register and `clear_flags` behave as above.
- Not defined: `sticky_flags` is constant 3'b000, `clear_flags` is ignored, and no sticky register is synthesized. Ports remain present.

## Structure
- **Shared package `fp_pkg`:**
  - Constants: QNAN=32'h7FC00000, POS_INF=32'h7F800000, EXP_MAX=8'hFF.
  - Flag bit indices: FLG_INVALID=2, FLG_OVERFLOW=1, FLG_NAN_IN=0.
  - Classification functions: is_nan, is_inf, is_zero.
- **Sub-modules.**
  - Existing: `fp_tree_multiplier`, instantiated unchanged.
  - New: `fp_result_fifo`, parameterised by DEPTH and width 35.

## Test plan
- 3F800000 × 40000000 with out_ready=1 → out_valid two cycles after accept; result 40000000, flags 000.
- 7F800000 × 00000000 → 7FC00000, flags 100; sticky_flags=100.
- 7F7FFFFF × 40000000 → 7F800000, flags 010. Then 7F800000 × 3F800000 → 7F800000, flags 000.
- 7FC00000 × 3F800000 → 7FC00000, flags 101. Assert clear_flags on the same cycle as the next write of 41200000 × C1A00000 → result C3480000; sticky=000.
- out_ready=0, push DEPTH+2 pairs → count=4, S1 held, in_ready=0. Then release out_ready → all 5 results emerge in order, none lost.
- Assert rst while count=3 and S1 valid → next cycle count=0, out_valid=0, in_ready=1, sticky=000.
